main_mem_responder: RTL and testbench

- Line-granularity backing-memory model that answers the cache's miss-side interface: refill reads and dirty-line writebacks, one whole line per transaction.
- Applies a fixed, parameterised access latency and signals completion with a one-cycle grant pulse.
- Counts completed reads and writes so benches can report memory traffic.
- Sits below `cache` in simulation and lab top-levels, in place of a real DRAM controller.

---
 rtl/mem_pkg.sv | 16 +
 rtl/line_store.sv | 22 ++
 rtl/main_mem_responder.sv | 112 +++++++++++
 tb/tb_main_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the line-granularity backing-memory model.
package mem_pkg;

  localparam int WORD_W        = 32;
  localparam int LINE_ADDR_LEN = 3;

  typedef logic [(WORD_W << LINE_ADDR_LEN)-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/line_store.sv
// Single-port line array: synchronous write, asynchronous read on the same index.
module line_store #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: the array has no reset port; resetting a memory costs a mux per bit and contents must survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency line memory answering cache refills and writebacks, with traffic counters.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN  = 3,
  parameter int MEM_ADDR_LEN   = 14,
  parameter int STORE_ADDR_LEN = 6,
  parameter int LATENCY        = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   mem_rd_req,
  input  logic                                   mem_wr_req,
  input  logic [MEM_ADDR_LEN-1:0]                mem_addr,
  input  logic [(WORD_W << LINE_ADDR_LEN)-1:0]   mem_wr_line,
  output logic [(WORD_W << LINE_ADDR_LEN)-1:0]   mem_rd_line,
  output logic                                   mem_gnt,
  output logic                                   busy,
  output logic [31:0]                            rd_cnt,
  output logic [31:0]                            wr_cnt
);

  localparam int LINE_W = WORD_W << LINE_ADDR_LEN;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [STORE_ADDR_LEN-1:0] idx_q;
  logic [LINE_W-1:0]         line_q;
  logic [LINE_W-1:0]         store_rdata;
  logic                      accept, store_we, rd_fire;

  // Upper address bits only alias into the backed store.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[MEM_ADDR_LEN-1:STORE_ADDR_LEN];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_wr_req) begin
          state_nxt = WR_WAIT;
          cnt_nxt   = CNT_LOAD;
        end else if (mem_rd_req) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && (mem_wr_req || mem_rd_req);
    store_we = (state == WR_WAIT) && (cnt == '0);
    rd_fire  = (state == RD_WAIT) && (cnt == '0);
    busy     = (state != IDLE);
  end

  // Request address and data are captured once; the cache may change them while waiting.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= mem_addr[STORE_ADDR_LEN-1:0];
      line_q <= mem_wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_gnt     <= 1'b0;
      mem_rd_line <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      mem_gnt     <= store_we || rd_fire;
      mem_rd_line <= rd_fire ? store_rdata : '0;
      if (rd_fire)  rd_cnt <= rd_cnt + 32'd1;
      if (store_we) wr_cnt <= wr_cnt + 32'd1;
    end
  end

  line_store #(
    .ADDR_W (STORE_ADDR_LEN),
    .DATA_W (LINE_W)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .addr  (idx_q),
    .wdata (line_q),
    .rdata (store_rdata)
  );

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench: table vectors, directed corner sequences and a randomized model comparison.
module tb_main_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [13:0] addr;
  line_t       wr_line, rd_line;
  logic        gnt, busy;
  logic [31:0] rd_cnt, wr_cnt;

  logic        rd_req1, wr_req1;
  logic [13:0] addr1;
  line_t       wr_line1, rd_line1;
  logic        gnt1, busy1;
  logic [31:0] rd_cnt1, wr_cnt1;

  int n_checks = 0;
  int n_err    = 0;

  line_t model_mem [64];
  int    exp_rd = 0;
  int    exp_wr = 0;

  always #5 clk = ~clk;

  main_mem_responder #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_rd_req(rd_req), .mem_wr_req(wr_req), .mem_addr(addr),
    .mem_wr_line(wr_line), .mem_rd_line(rd_line), .mem_gnt(gnt), .busy(busy),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  main_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_rd_req(rd_req1), .mem_wr_req(wr_req1), .mem_addr(addr1),
    .mem_wr_line(wr_line1), .mem_rd_line(rd_line1), .mem_gnt(gnt1), .busy(busy1),
    .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic line_t fill_line(input logic [31:0] w);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = w;
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Single-request transaction; starts and ends on a falling edge with the DUT idle.
  task automatic run_txn(input bit wr, input logic [13:0] a, input line_t wl,
                         input string tag, output line_t got);
    int cyc = 0;
    bit seen = 0;
    wr_req = wr; rd_req = !wr; addr = a; wr_line = wl;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt) seen = 1;
    end
    check({tag, " grant_latency"}, 256'(cyc), 256'(LAT + 1));
    check({tag, " busy_at_grant"}, 256'(busy), 256'(1));
    got = rd_line;
    if (wr) begin
      model_mem[a[5:0]] = wl;
      exp_wr++;
    end else begin
      exp_rd++;
    end
    wr_req = 0; rd_req = 0;
    @(negedge clk);
    check({tag, " gnt_pulse_ends"}, 256'(gnt), 256'(0));
    check({tag, " rd_line_idle"}, rd_line, 256'(0));
    check({tag, " busy_after_done"}, 256'(busy), 256'(0));
    check({tag, " rd_cnt"}, 256'(rd_cnt), 256'(exp_rd));
    check({tag, " wr_cnt"}, 256'(wr_cnt), 256'(exp_wr));
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    line_t       wline;
    line_t       exp_line;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000 ns");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [6];
    line_t l23, laa, l07, got, old3;
    int    cyc;
    bit    seen;
    logic [7:0] mask;

    l23 = {32'h30, 32'h8b, 32'h7b, 32'h6b, 32'h5b, 32'h4b, 32'h3b, 32'h2b};
    laa = fill_line(32'h0AA);
    l07 = fill_line(32'h07070707);
    for (int i = 0; i < 64; i++) model_mem[i] = '0;

    vecs[0] = '{wr: 1'b0, addr: 14'h005, wline: '0,  exp_line: '0};
    vecs[1] = '{wr: 1'b1, addr: 14'h003, wline: l23, exp_line: '0};
    vecs[2] = '{wr: 1'b0, addr: 14'h003, wline: '0,  exp_line: l23};
    vecs[3] = '{wr: 1'b1, addr: 14'h001, wline: laa, exp_line: '0};
    vecs[4] = '{wr: 1'b0, addr: 14'h041, wline: '0,  exp_line: laa};
    vecs[5] = '{wr: 1'b0, addr: 14'h3FC1, wline: '0, exp_line: laa};

    rst = 1; rd_req = 0; wr_req = 0; addr = '0; wr_line = '0;
    rd_req1 = 0; wr_req1 = 0; addr1 = '0; wr_line1 = '0;
    #1 rst = 0;
    repeat (2) @(negedge clk);
    check("reset gnt", 256'(gnt), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    check("reset rd_line", rd_line, 256'(0));
    check("reset rd_cnt", 256'(rd_cnt), 256'(0));
    check("reset wr_cnt", 256'(wr_cnt), 256'(0));
    rst = 1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wline, $sformatf("vec%0d", i), got);
      if (!vecs[i].wr) check($sformatf("vec%0d rd_data", i), got, vecs[i].exp_line);
    end

    // Both requests together: the write is served first, the held read follows.
    wr_req = 1; rd_req = 1; addr = 14'h004; wr_line = l07;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++; if (gnt) seen = 1;
    end
    check("simul first_latency", 256'(cyc), 256'(LAT + 1));
    check("simul first_is_write", 256'(wr_cnt), 256'(exp_wr + 1));
    check("simul first_no_read", 256'(rd_cnt), 256'(exp_rd));
    check("simul write_rd_line", rd_line, 256'(0));
    exp_wr++; model_mem[4] = l07;
    wr_req = 0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++; if (gnt) seen = 1;
    end
    check("simul second_gap", 256'(cyc), 256'(LAT + 2));
    check("simul read_data", rd_line, l07);
    exp_rd++;
    check("simul rd_cnt", 256'(rd_cnt), 256'(exp_rd));
    rd_req = 0;
    @(negedge clk);
    check("simul idle", 256'(busy), 256'(0));

    // Reset four cycles into a write must drop it entirely.
    old3 = model_mem[3];
    wr_req = 1; addr = 14'h003; wr_line = ~l23;
    repeat (4) @(negedge clk);
    check("abort busy_before", 256'(busy), 256'(1));
    rst = 0; wr_req = 0;
    repeat (2) @(negedge clk);
    check("abort busy_in_reset", 256'(busy), 256'(0));
    check("abort wr_cnt", 256'(wr_cnt), 256'(0));
    rst = 1;
    exp_rd = 0; exp_wr = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk); if (gnt) seen = 1;
    end
    check("abort no_grant", 256'(seen), 256'(0));
    run_txn(1'b0, 14'h003, '0, "abort_read", got);
    check("abort read_old", got, old3);

    // LATENCY=1 instance: held read with an address change at the grant.
    rd_req1 = 1; addr1 = 14'h010;
    mask = '0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (gnt1) begin
        mask[i] = 1'b1;
        check($sformatf("lat1 rd_data_%0d", i), rd_line1, 256'(0));
        addr1 = 14'h011;
      end
      if (i == 5) rd_req1 = 0;
    end
    check("lat1 grant_pattern", 256'(mask), 256'(8'b0010_0100));
    check("lat1 rd_cnt", 256'(rd_cnt1), 256'(2));

    // Randomized traffic against the array model.
    for (int t = 0; t < 40; t++) begin
      bit          w;
      logic [13:0] a;
      line_t       l, exp_l;
      w = 1'($urandom_range(0, 1));
      a = 14'($urandom_range(0, 255) * 64 + $urandom_range(0, 7));
      l = rand_line();
      exp_l = model_mem[a[5:0]];
      run_txn(w, a, l, $sformatf("rand%0d", t), got);
      if (!w) check($sformatf("rand%0d rd_data", t), got, exp_l);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
